mmio_test_responder: RTL and testbench

Memory-mapped responder on the CPU data-memory bus: decodes a small MMIO window and answers the stores and loads that `PipelinedCPU` issues. It implements the riscv-tests `tohost` completion protocol, an LED register, a free-running cycle counter and an optional watchdog. Its done/pass/fail status lets benches and FPGA tops end a run without probing memory internals. It sits beside `DataMemory`; the top selects `mmio_rdata` over RAM data whenever `mmio_hit` is high.

---
 rtl/mmio_test_responder.sv | 135 +++++++++++++
 tb/tb_mmio_test_responder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mmio_test_responder.sv
// MMIO responder: riscv-tests tohost completion, LED register, 64-bit cycle counter.
// Optional watchdog built when MMIO_WATCHDOG_EN is defined; loads are zero-wait, stores land next edge.
module mmio_test_responder #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    LED_WIDTH      = 8,
  parameter logic [ADDR_WIDTH-1:0] TOHOST_ADDR    = 32'h0000_1000,
  parameter logic [ADDR_WIDTH-1:0] LED_ADDR       = 32'h0000_1004,
  parameter logic [ADDR_WIDTH-1:0] CYCLE_ADDR     = 32'h0000_1008,
  parameter int unsigned           TIMEOUT_CYCLES = 5_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] dmem_addr,
  input  logic [DATA_WIDTH-1:0] dmem_wdata,
  input  logic                  dmem_we,
  input  logic [3:0]            dmem_be,
  output logic                  mmio_hit,
  output logic [DATA_WIDTH-1:0] mmio_rdata,
  output logic [LED_WIDTH-1:0]  leds_out,
  output logic                  test_done,
  output logic                  test_pass,
  output logic [30:0]           test_code,
  output logic                  timeout
);
  localparam logic [1:0] RUN  = 2'd0;
  localparam logic [1:0] PASS = 2'd1;
  localparam logic [1:0] FAIL = 2'd2;
  localparam logic [ADDR_WIDTH-1:0] CYCHI_ADDR = ADDR_WIDTH'(CYCLE_ADDR + 4);

  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] tohost_q, tohost_d;
  logic [LED_WIDTH-1:0]  led_q, led_d;
  logic [63:0]           cycle_q, cycle_d;
  logic [30:0]           code_q, code_d;
  logic                  hit_tohost, hit_led, hit_cyclo, hit_cychi, tohost_acc, led_store;
  logic                  wdog_expire;
  logic                  unused_addr_lsb;

  assign unused_addr_lsb = ^dmem_addr[1:0];
  assign hit_tohost = dmem_addr[ADDR_WIDTH-1:2] == TOHOST_ADDR[ADDR_WIDTH-1:2];
  assign hit_led    = dmem_addr[ADDR_WIDTH-1:2] == LED_ADDR[ADDR_WIDTH-1:2];
  assign hit_cyclo  = dmem_addr[ADDR_WIDTH-1:2] == CYCLE_ADDR[ADDR_WIDTH-1:2];
  assign hit_cychi  = dmem_addr[ADDR_WIDTH-1:2] == CYCHI_ADDR[ADDR_WIDTH-1:2];
  assign mmio_hit   = hit_tohost | hit_led | hit_cyclo | hit_cychi;

  // Only full-word odd values count; even values are syscall requests.
  assign tohost_acc = dmem_we && hit_tohost && (dmem_be == 4'hF) && (state_q == RUN) && dmem_wdata[0];
  assign led_store  = dmem_we && hit_led;

`ifdef MMIO_WATCHDOG_EN
  localparam logic [1:0] TMO = 2'd3;
  logic [31:0] wdog_q, wdog_d;

  assign wdog_expire = (state_q == RUN) && (wdog_q == 32'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wdog_d = wdog_q;
    if (led_store)           wdog_d = '0;
    else if (state_q == RUN) wdog_d = wdog_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) wdog_q <= '0;
    else     wdog_q <= wdog_d;
  end

  assign timeout = (state_q == TMO);
`else
  localparam int unsigned UNUSED_TIMEOUT = TIMEOUT_CYCLES;
  assign wdog_expire = 1'b0;
  assign timeout     = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    tohost_d = tohost_q;
    code_d   = code_q;
    if (tohost_acc) begin
      tohost_d = dmem_wdata;
      if (dmem_wdata == DATA_WIDTH'(1)) begin
        state_d = PASS;
      end else begin
        state_d = FAIL;
        code_d  = dmem_wdata[31:1];
      end
    end
`ifdef MMIO_WATCHDOG_EN
    else if (wdog_expire) begin
      state_d = TMO;
    end
`endif
  end

  // Freezing on the completing edge makes the count read in the store cycle final.
  assign cycle_d = ((state_q == RUN) && (state_d == RUN)) ? cycle_q + 64'd1 : cycle_q;

  always_comb begin
    led_d = led_q;
    if (led_store) begin
      for (int i = 0; i < LED_WIDTH; i++) begin
        if (dmem_be[i/8]) led_d[i] = dmem_wdata[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      tohost_q <= '0;
      led_q    <= '0;
      cycle_q  <= '0;
      code_q   <= '0;
    end else begin
      state_q  <= state_d;
      tohost_q <= tohost_d;
      led_q    <= led_d;
      cycle_q  <= cycle_d;
      code_q   <= code_d;
    end
  end

  always_comb begin
    mmio_rdata = '0;
    if (hit_tohost)     mmio_rdata = tohost_q;
    else if (hit_led)   mmio_rdata = DATA_WIDTH'(led_q);
    else if (hit_cyclo) mmio_rdata = DATA_WIDTH'(cycle_q[31:0]);
    else if (hit_cychi) mmio_rdata = DATA_WIDTH'(cycle_q[63:32]);
  end

  assign leds_out  = led_q;
  assign test_done = (state_q != RUN);
  assign test_pass = (state_q == PASS);
  assign test_code = code_q;
endmodule

// File: tb/tb_mmio_test_responder.sv
// Scoreboard bench for mmio_test_responder: stimulus queues expected values, a negedge monitor checks them.
module tb_mmio_test_responder;
  localparam logic [31:0] TOHOST = 32'h0000_1000;
  localparam logic [31:0] LED    = 32'h0000_1004;
  localparam logic [31:0] CYC    = 32'h0000_1008;
`ifdef MMIO_WATCHDOG_EN
  localparam int unsigned TLIM = 16;
`else
  localparam int unsigned TLIM = 5_000_000;
`endif
  localparam int S_HIT = 0, S_RDATA = 1, S_LEDS = 2, S_DONE = 3, S_PASS = 4, S_CODE = 5, S_TMO = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] dmem_addr = '0;
  logic [31:0] dmem_wdata = '0;
  logic        dmem_we = 1'b0;
  logic [3:0]  dmem_be = '0;
  logic        mmio_hit;
  logic [31:0] mmio_rdata;
  logic [7:0]  leds_out;
  logic        test_done, test_pass, timeout;
  logic [30:0] test_code;

  mmio_test_responder #(.TIMEOUT_CYCLES(TLIM)) dut (
    .clk(clk), .rst(rst), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_we(dmem_we), .dmem_be(dmem_be), .mmio_hit(mmio_hit), .mmio_rdata(mmio_rdata),
    .leds_out(leds_out), .test_done(test_done), .test_pass(test_pass),
    .test_code(test_code), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    int          sel;
    logic [63:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   c0 = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t        mon_e;
  logic [63:0] mon_act;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] sample(int sel);
    case (sel)
      S_HIT:   return 64'(mmio_hit);
      S_RDATA: return 64'(mmio_rdata);
      S_LEDS:  return 64'(leds_out);
      S_DONE:  return 64'(test_done);
      S_PASS:  return 64'(test_pass);
      S_CODE:  return 64'(test_code);
      default: return 64'(timeout);
    endcase
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      mon_e   = sb.pop_front();
      mon_act = sample(mon_e.sel);
      n_cmp++;
      if (mon_act !== mon_e.val) begin
        n_bad++;
        $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", mon_e.name, cyc, mon_act, mon_e.val);
      end
    end
  end

  task automatic push_exp(int sel, logic [63:0] val, int off, string name);
    exp_t e;
    int   idx;
    e.due = cyc + off; e.sel = sel; e.val = val; e.name = name;
    idx = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].due > e.due) begin idx = i; break; end
    end
    sb.insert(idx, e);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(logic [31:0] a, logic [31:0] d, logic we, logic [3:0] be);
    dmem_addr = a; dmem_wdata = d; dmem_we = we; dmem_be = be;
  endtask

  task automatic idle();
    drive(32'h0000_0000, 32'h0, 1'b0, 4'h0);
  endtask

  task automatic store(logic [31:0] a, logic [31:0] d, logic [3:0] be);
    drive(a, d, 1'b1, be);
    tick();
    idle();
  endtask

  task automatic do_reset();
    rst = 1'b1; idle(); tick(); tick(); rst = 1'b0; c0 = cyc;
  endtask

  initial begin
    int fin;
    do_reset();
    n_cmp++;
    if (test_done !== 1'b0) begin n_bad++; $display("FAIL direct_rst_done: got %0b", test_done); end
    n_cmp++;
    if (test_pass !== 1'b0) begin n_bad++; $display("FAIL direct_rst_pass: got %0b", test_pass); end
    n_cmp++;
    if (timeout !== 1'b0) begin n_bad++; $display("FAIL direct_rst_timeout: got %0b", timeout); end
    n_cmp++;
    if (leds_out !== 8'h00) begin n_bad++; $display("FAIL direct_rst_leds: got 0x%0h", leds_out); end
    n_cmp++;
    if (test_code !== 31'd0) begin n_bad++; $display("FAIL direct_rst_code: got 0x%0h", test_code); end
    n_cmp++;
    if (mmio_hit !== 1'b0) begin n_bad++; $display("FAIL direct_rst_hit: got %0b", mmio_hit); end
    push_exp(S_LEDS, 0, 0, "rst_leds");
    push_exp(S_DONE, 0, 0, "rst_done");
    push_exp(S_PASS, 0, 0, "rst_pass");
    push_exp(S_CODE, 0, 0, "rst_code");
    push_exp(S_TMO,  0, 0, "rst_timeout");
    push_exp(S_HIT,  0, 0, "rst_hit");
    push_exp(S_RDATA, 0, 0, "rst_rdata");
`ifdef MMIO_WATCHDOG_EN
    push_exp(S_TMO,  0, 15, "wd_before_expiry");
    push_exp(S_TMO,  1, 16, "wd_expired");
    push_exp(S_DONE, 1, 16, "wd_done");
    push_exp(S_PASS, 0, 16, "wd_not_pass");
    repeat (17) tick();
    drive(CYC, 0, 1'b0, 4'h0); push_exp(S_RDATA, 15, 0, "wd_cycle_frozen"); tick();

    do_reset();
    repeat (15) tick();
    drive(TOHOST, 32'h1, 1'b1, 4'hF); tick(); idle();
    push_exp(S_PASS, 1, 0, "wd_race_pass");
    push_exp(S_TMO,  0, 0, "wd_race_no_timeout");
    push_exp(S_DONE, 1, 0, "wd_race_done");

    do_reset();
    repeat (10) tick();
    store(LED, 32'h1, 4'hF);
    push_exp(S_TMO, 0, 15, "wd_heartbeat_holds");
    push_exp(S_TMO, 1, 16, "wd_heartbeat_expiry");
    repeat (17) tick();

    rst = 1'b1; tick();
    push_exp(S_TMO,  0, 0, "wd_rst_timeout");
    push_exp(S_DONE, 0, 0, "wd_rst_done");
    push_exp(S_LEDS, 0, 0, "wd_rst_leds");
    rst = 1'b0; tick();
`else
    repeat (100) tick();
    drive(CYC, 0, 1'b0, 4'h0);
    push_exp(S_RDATA, 100, 0, "cycle_lo_100"); push_exp(S_HIT, 1, 0, "cycle_hit"); tick();
    drive(CYC + 4, 0, 1'b0, 4'h0); push_exp(S_RDATA, 0, 0, "cycle_hi_0"); push_exp(S_HIT, 1, 0, "cycle_hi_hit"); tick();
    drive(CYC + 2, 0, 1'b0, 4'h0); push_exp(S_RDATA, 64'(cyc - c0), 0, "cycle_byte_offset"); tick();
    drive(32'h0000_1010, 0, 1'b0, 4'h0);
    push_exp(S_HIT, 0, 0, "unmapped_hit"); push_exp(S_RDATA, 0, 0, "unmapped_rdata"); tick();
    drive(TOHOST, 0, 1'b0, 4'h0); push_exp(S_RDATA, 0, 0, "tohost_rst_val"); tick();

    store(TOHOST, 32'h2, 4'hF); push_exp(S_DONE, 0, 0, "syscall_ignored");
    drive(TOHOST, 0, 1'b0, 4'h0); push_exp(S_RDATA, 0, 0, "syscall_not_latched"); tick();
    store(TOHOST, 32'h1, 4'h1); push_exp(S_DONE, 0, 0, "partial_ignored");

    store(LED, 32'hA5A5_A5A5, 4'h1); push_exp(S_LEDS, 8'hA5, 0, "led_be1");
    drive(LED, 0, 1'b0, 4'h0); push_exp(S_RDATA, 32'hA5, 0, "led_read_zext"); tick();
    store(LED, 32'h5A5A_5A5A, 4'h2); push_exp(S_LEDS, 8'hA5, 0, "led_be2_unchanged");
    drive(LED, 32'h3C, 1'b1, 4'hF);
    push_exp(S_RDATA, 32'hA5, 0, "same_cycle_old_val"); push_exp(S_LEDS, 8'h3C, 1, "led_full");
    tick(); idle();

    fin = cyc - c0;
    drive(TOHOST, 32'h1, 1'b1, 4'hF); tick(); idle();
    push_exp(S_DONE, 1, 0, "pass_done"); push_exp(S_PASS, 1, 0, "pass_pass");
    push_exp(S_CODE, 0, 0, "pass_code"); push_exp(S_TMO, 0, 0, "pass_timeout");
    drive(CYC, 0, 1'b0, 4'h0); push_exp(S_RDATA, 64'(fin), 0, "final_count"); tick();
    store(CYC, 32'hFFFF_FFFF, 4'hF);
    repeat (5) tick();
    drive(CYC, 0, 1'b0, 4'h0); push_exp(S_RDATA, 64'(fin), 0, "count_frozen"); tick();

    do_reset();
    push_exp(S_DONE, 0, 0, "rerst_done");
    drive(TOHOST, 0, 1'b0, 4'h0); push_exp(S_RDATA, 0, 0, "rerst_tohost"); tick();
    store(TOHOST, 32'h7, 4'hF);
    push_exp(S_DONE, 1, 0, "fail_done"); push_exp(S_PASS, 0, 0, "fail_pass"); push_exp(S_CODE, 3, 0, "fail_code");
    drive(TOHOST, 0, 1'b0, 4'h0); push_exp(S_RDATA, 7, 0, "fail_tohost_val"); tick();
    store(TOHOST, 32'h1, 4'hF);
    push_exp(S_PASS, 0, 0, "fail_sticky_pass"); push_exp(S_CODE, 3, 0, "fail_sticky_code");
    drive(TOHOST, 0, 1'b0, 4'h0); push_exp(S_RDATA, 7, 0, "fail_tohost_kept"); tick();
    store(LED, 32'h11, 4'hF); push_exp(S_LEDS, 8'h11, 0, "led_in_fail");

    rst = 1'b1; tick();
    push_exp(S_LEDS, 0, 0, "midrst_leds"); push_exp(S_DONE, 0, 0, "midrst_done");
    push_exp(S_CODE, 0, 0, "midrst_code");
    rst = 1'b0;
    drive(CYC, 0, 1'b0, 4'h0); push_exp(S_RDATA, 0, 0, "midrst_cycle"); tick();
`endif
    idle();
    for (int k = 0; k < 4 && sb.size() > 0; k++) tick();
    while (sb.size() > 0) begin
      mon_e = sb.pop_front();
      n_cmp++; n_bad++;
      $display("FAIL %s: never checked, expected 0x%0h", mon_e.name, mon_e.val);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
